// File: rtl/av2_mv_decode_ctrl.sv
// Motion-vector decode sequencer: one decoder run per reference of a block,
// final MV = predictor + decoded difference, saturated, streamed out.
module av2_mv_decode_ctrl #(
  parameter int unsigned BLK_ID_W       = 12,
  parameter int unsigned MV_CLAMP       = 16383,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [BLK_ID_W-1:0] blk_id,
  input  logic                blk_is_compound,
  input  logic signed [15:0]  pred0_x,
  input  logic signed [15:0]  pred0_y,
  input  logic signed [15:0]  pred1_x,
  input  logic signed [15:0]  pred1_y,
  output logic                dec_start,
  input  logic                dec_done,
  input  logic signed [15:0]  dec_mv_x,
  input  logic signed [15:0]  dec_mv_y,
  input  logic                dec_mv_valid,
  output logic                dec_mv_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLK_ID_W-1:0] out_blk_id,
  output logic                out_ref,
  output logic                out_last,
  output logic signed [15:0]  out_mv_x,
  output logic signed [15:0]  out_mv_y,
  output logic                out_timeout,
  output logic                busy,
  output logic                err_timeout,
  input  logic                err_clear
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [16:0] CLAMP_HI = 17'(MV_CLAMP);
  localparam logic signed [16:0] CLAMP_LO = -CLAMP_HI;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_MV = 3'd2,
    SUM     = 3'd3,
    OUTPUT  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [BLK_ID_W-1:0] id_q, id_d;
  logic                cmp_q, cmp_d;
  logic signed [15:0]  p0x_q, p0x_d, p0y_q, p0y_d, p1x_q, p1x_d, p1y_q, p1y_d;
  logic signed [15:0]  dfx_q, dfx_d, dfy_q, dfy_d;
  logic                ref_q, ref_d;
  logic                to_q, to_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                blk_ready_q, blk_ready_d;
  logic                dec_start_q, dec_start_d;
  logic                dec_mv_ready_q, dec_mv_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [BLK_ID_W-1:0] out_blk_id_q, out_blk_id_d;
  logic                out_ref_q, out_ref_d;
  logic                out_last_q, out_last_d;
  logic signed [15:0]  out_mv_x_q, out_mv_x_d, out_mv_y_q, out_mv_y_d;
  logic                out_timeout_q, out_timeout_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // 17-bit signed add of predictor and difference, saturated to +/-MV_CLAMP
  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s > CLAMP_HI)      sat_add = CLAMP_HI[15:0];
    else if (s < CLAMP_LO) sat_add = CLAMP_LO[15:0];
    else                   sat_add = s[15:0];
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    cmp_d         = cmp_q;
    p0x_d         = p0x_q;
    p0y_d         = p0y_q;
    p1x_d         = p1x_q;
    p1y_d         = p1y_q;
    dfx_d         = dfx_q;
    dfy_d         = dfy_q;
    ref_d         = ref_q;
    to_d          = to_q;
    cnt_d         = cnt_q;
    dec_start_d   = 1'b0;
    out_blk_id_d  = out_blk_id_q;
    out_ref_d     = out_ref_q;
    out_last_d    = out_last_q;
    out_mv_x_d    = out_mv_x_q;
    out_mv_y_d    = out_mv_y_q;
    out_timeout_d = out_timeout_q;
    err_d         = err_q & ~err_clear;

    unique case (state_q)
      IDLE: begin
        if (blk_valid && blk_ready_q) begin
          id_d    = blk_id;
          cmp_d   = blk_is_compound;
          p0x_d   = pred0_x;
          p0y_d   = pred0_y;
          p1x_d   = pred1_x;
          p1y_d   = pred1_y;
          ref_d   = 1'b0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (dec_done) begin
          dec_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_MV;
        end
      end
      WAIT_MV: begin
        if (dec_mv_valid && dec_mv_ready_q) begin
          dfx_d   = dec_mv_x;
          dfy_d   = dec_mv_y;
          to_d    = 1'b0;
          state_d = SUM;
        end else if (cnt_q == CNT_LAST) begin
          dfx_d   = '0;
          dfy_d   = '0;
          to_d    = 1'b1;
          err_d   = 1'b1;
          state_d = SUM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SUM: begin
        out_mv_x_d    = sat_add(ref_q ? p1x_q : p0x_q, dfx_q);
        out_mv_y_d    = sat_add(ref_q ? p1y_q : p0y_q, dfy_q);
        out_blk_id_d  = id_q;
        out_ref_d     = ref_q;
        out_last_d    = ref_q || !cmp_q;
        out_timeout_d = to_q;
        state_d       = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            ref_d   = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    blk_ready_d    = (state_d == IDLE);
    dec_mv_ready_d = (state_d == WAIT_MV);
    out_valid_d    = (state_d == OUTPUT);
    busy_d         = (state_d != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      id_q           <= '0;
      cmp_q          <= 1'b0;
      p0x_q          <= '0;
      p0y_q          <= '0;
      p1x_q          <= '0;
      p1y_q          <= '0;
      dfx_q          <= '0;
      dfy_q          <= '0;
      ref_q          <= 1'b0;
      to_q           <= 1'b0;
      cnt_q          <= '0;
      blk_ready_q    <= 1'b0;
      dec_start_q    <= 1'b0;
      dec_mv_ready_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_blk_id_q   <= '0;
      out_ref_q      <= 1'b0;
      out_last_q     <= 1'b0;
      out_mv_x_q     <= '0;
      out_mv_y_q     <= '0;
      out_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      cmp_q          <= cmp_d;
      p0x_q          <= p0x_d;
      p0y_q          <= p0y_d;
      p1x_q          <= p1x_d;
      p1y_q          <= p1y_d;
      dfx_q          <= dfx_d;
      dfy_q          <= dfy_d;
      ref_q          <= ref_d;
      to_q           <= to_d;
      cnt_q          <= cnt_d;
      blk_ready_q    <= blk_ready_d;
      dec_start_q    <= dec_start_d;
      dec_mv_ready_q <= dec_mv_ready_d;
      out_valid_q    <= out_valid_d;
      out_blk_id_q   <= out_blk_id_d;
      out_ref_q      <= out_ref_d;
      out_last_q     <= out_last_d;
      out_mv_x_q     <= out_mv_x_d;
      out_mv_y_q     <= out_mv_y_d;
      out_timeout_q  <= out_timeout_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign blk_ready    = blk_ready_q;
  assign dec_start    = dec_start_q;
  assign dec_mv_ready = dec_mv_ready_q;
  assign out_valid    = out_valid_q;
  assign out_blk_id   = out_blk_id_q;
  assign out_ref      = out_ref_q;
  assign out_last     = out_last_q;
  assign out_mv_x     = out_mv_x_q;
  assign out_mv_y     = out_mv_y_q;
  assign out_timeout  = out_timeout_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_av2_mv_decode_ctrl.sv
// Scoreboard bench for av2_mv_decode_ctrl with a small MV-decoder model.
module tb_av2_mv_decode_ctrl;

  localparam int BLK_ID_W = 12;

  typedef struct { int id; int rf; int last; int x; int y; int to; } exp_t;
  typedef struct { int x; int y; int dly; bit never; } dec_t;

  logic clk, rst_n;
  logic blk_valid, blk_ready, blk_is_compound;
  logic [BLK_ID_W-1:0] blk_id, out_blk_id;
  logic signed [15:0] pred0_x, pred0_y, pred1_x, pred1_y;
  logic dec_start, dec_done, dec_mv_valid, dec_mv_ready;
  logic signed [15:0] dec_mv_x, dec_mv_y, out_mv_x, out_mv_y;
  logic out_valid, out_ready, out_ref, out_last, out_timeout;
  logic busy, err_timeout, err_clear;

  exp_t sb[$];
  dec_t dq[$];
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ready_cnt = 0;

  av2_mv_decode_ctrl #(.BLK_ID_W(BLK_ID_W), .MV_CLAMP(16383), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_id(blk_id),
    .blk_is_compound(blk_is_compound),
    .pred0_x(pred0_x), .pred0_y(pred0_y), .pred1_x(pred1_x), .pred1_y(pred1_y),
    .dec_start(dec_start), .dec_done(dec_done),
    .dec_mv_x(dec_mv_x), .dec_mv_y(dec_mv_y),
    .dec_mv_valid(dec_mv_valid), .dec_mv_ready(dec_mv_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_blk_id(out_blk_id),
    .out_ref(out_ref), .out_last(out_last),
    .out_mv_x(out_mv_x), .out_mv_y(out_mv_y), .out_timeout(out_timeout),
    .busy(busy), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start pulses and WAIT_MV residency, counted at the falling edge
  initial forever begin
    @(negedge clk);
    if (dec_start) start_cnt++;
    if (dec_mv_ready) ready_cnt++;
  end

  // Scoreboard monitor: compare each output handshake against the queue head
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_blk_id", int'(out_blk_id), e.id);
        chk("out_ref", int'(out_ref), e.rf);
        chk("out_last", int'(out_last), e.last);
        chk("out_mv_x", int'(out_mv_x), e.x);
        chk("out_mv_y", int'(out_mv_y), e.y);
        chk("out_timeout", int'(out_timeout), e.to);
      end
    end
  end

  // MV decoder model: after each start, optionally return one difference
  initial begin
    dec_t d;
    dec_mv_valid = 1'b0;
    dec_mv_x = '0;
    dec_mv_y = '0;
    forever begin
      @(posedge clk); #1;
      if (dec_start) begin
        if (dq.size() == 0) chk("dec_unexpected_start", 1, 0);
        else begin
          d = dq.pop_front();
          if (!d.never) begin
            repeat (d.dly) begin @(posedge clk); #1; end
            dec_mv_x = 16'(d.x);
            dec_mv_y = 16'(d.y);
            dec_mv_valid = 1'b1;
            @(posedge clk); #1;
            dec_mv_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_blk(input int id, input int cmp, input int ax, input int ay,
                          input int bx, input int by);
    int n = 0;
    while (!blk_ready && n < 100) begin cyc(1); n++; end
    chk("blk_ready_wait", int'(blk_ready), 1);
    blk_id = 12'(id);
    blk_is_compound = cmp[0];
    pred0_x = 16'(ax); pred0_y = 16'(ay);
    pred1_x = 16'(bx); pred1_y = 16'(by);
    blk_valid = 1'b1;
    cyc(1);
    blk_valid = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin cyc(1); n++; end
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, int'({blk_ready, dec_start, dec_mv_ready, out_valid, out_ref,
                             out_last, out_timeout, busy, err_timeout}), 0);
    chk({tag, "_id"}, int'(out_blk_id), 0);
    chk({tag, "_mvx"}, int'(out_mv_x), 0);
    chk({tag, "_mvy"}, int'(out_mv_y), 0);
  endtask

  // Hard stop if the flow ever wedges
  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, r0, n;
    rst_n = 1'b0; blk_valid = 1'b0; blk_id = '0; blk_is_compound = 1'b0;
    pred0_x = '0; pred0_y = '0; pred1_x = '0; pred1_y = '0;
    dec_done = 1'b1; out_ready = 1'b1; err_clear = 1'b0;
    cyc(2);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(1);
    chk("idle_blk_ready", int'(blk_ready), 1);

    // single reference; pred1 must be ignored
    dq.push_back('{3, 4, 0, 1'b0});
    sb.push_back('{7, 0, 1, 13, -1, 0});
    s0 = start_cnt; r0 = ready_cnt;
    send_blk(7, 0, 10, -5, 999, 999);
    wait_sb();
    chk("single_starts", start_cnt - s0, 1);
    chk("single_wait_cycles", ready_cnt - r0, 1);

    // compound
    dq.push_back('{1, 2, 1, 1'b0});
    dq.push_back('{-200, -50, 3, 1'b0});
    sb.push_back('{33, 0, 0, 1, 2, 0});
    sb.push_back('{33, 1, 1, -100, 50, 0});
    s0 = start_cnt;
    send_blk(33, 1, 0, 0, 100, 100);
    wait_sb();
    chk("compound_starts", start_cnt - s0, 2);

    // clamp
    dq.push_back('{10, -10, 0, 1'b0});
    sb.push_back('{3, 0, 1, 16383, -16383, 0});
    send_blk(3, 0, 16380, -16380, 0, 0);
    wait_sb();
    dq.push_back('{32767, -32768, 0, 1'b0});
    sb.push_back('{4, 0, 1, 16383, -16383, 0});
    send_blk(4, 0, 32767, -32768, 0, 0);
    wait_sb();

    // start gating on dec_done
    dec_done = 1'b0;
    dq.push_back('{0, 0, 0, 1'b0});
    sb.push_back('{5, 0, 1, 1, 1, 0});
    s0 = start_cnt;
    send_blk(5, 0, 1, 1, 0, 0);
    cyc(5);
    chk("gate_no_start", start_cnt - s0, 0);
    chk("gate_busy", int'(busy), 1);
    dec_done = 1'b1;
    wait_sb();
    chk("gate_starts", start_cnt - s0, 1);

    // output backpressure
    out_ready = 1'b0;
    dq.push_back('{2, -3, 0, 1'b0});
    sb.push_back('{6, 0, 1, -5, 5, 0});
    send_blk(6, 0, -7, 8, 0, 0);
    n = 0;
    while (!out_valid && n < 50) begin cyc(1); n++; end
    chk("bp_out_valid", int'(out_valid), 1);
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_mv_x_stable", int'(out_mv_x), -5);
      chk("bp_mv_y_stable", int'(out_mv_y), 5);
      chk("bp_blk_ready_low", int'(blk_ready), 0);
    end
    chk("bp_no_start", start_cnt - s0, 0);
    out_ready = 1'b1;
    wait_sb();

    // watchdog expiry: output equals predictor
    dq.push_back('{0, 0, 0, 1'b1});
    sb.push_back('{9, 0, 1, 50, -60, 1});
    r0 = ready_cnt;
    send_blk(9, 0, 50, -60, 0, 0);
    wait_sb();
    chk("wd_wait_cycles", ready_cnt - r0, 8);
    chk("wd_err_set", int'(err_timeout), 1);
    cyc(3);
    chk("wd_err_sticky", int'(err_timeout), 1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    chk("wd_err_cleared", int'(err_timeout), 0);

    // difference on the final watchdog cycle wins
    dq.push_back('{1, 1, 7, 1'b0});
    sb.push_back('{10, 0, 1, 6, 6, 0});
    r0 = ready_cnt;
    send_blk(10, 0, 5, 5, 0, 0);
    wait_sb();
    chk("wd_edge_wait_cycles", ready_cnt - r0, 8);
    chk("wd_edge_no_err", int'(err_timeout), 0);

    // reset during WAIT_MV abandons the block
    dq.push_back('{0, 0, 0, 1'b1});
    send_blk(11, 0, 40, 40, 0, 0);
    n = 0;
    while (!dec_mv_ready && n < 50) begin cyc(1); n++; end
    chk("rst_reached_wait", int'(dec_mv_ready), 1);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    cyc(1);
    rst_n = 1'b1;
    dq.push_back('{4, 5, 2, 1'b0});
    sb.push_back('{12, 0, 1, 6, 8, 0});
    send_blk(12, 0, 2, 3, 0, 0);
    wait_sb();

    cyc(5);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_dec_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
